calendar_ctrl: RTL and testbench
================================

// Module: calendar_ctrl
// PURPOSE
//   Sequencing/configuration controller for the BCD day/month calendar datapath.
//   Divides clk into a day-advance tick, advances a DD/MM date with correct month
//   lengths (non-leap year), and runs a 3-state mode FSM for user date setting.
//   It sits between the board buttons (pulses synchronized upstream) and the
//   7-segment display driver, which consumes du/dd/mu/md.
// PARAMETERS
//   TICK_DIV  4   clk cycles per day advance in RUN; legal range >= 2.
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   run_en     in   1  1 = allow the date to advance in RUN; 0 = pause
//   btn_mode   in   1  1-cycle pulse: step the mode FSM
//   btn_inc    in   1  1-cycle pulse: increment the field being set
//   du         out  4  day units, BCD
//   dd         out  4  day tens, BCD (0..3)
//   mu         out  4  month units, BCD
//   md         out  4  month tens, BCD (0..1)
//   mode       out  2  FSM state: 0 RUN, 1 SET_MONTH, 2 SET_DAY
//   day_tick   out  1  registered pulse: date advanced at the previous edge
//   year_wrap  out  1  registered pulse: 31/12 -> 01/01 at the previous edge
// BEHAVIOUR
//   Reset (async, no clock needed): date 01/01 (du=1 dd=0 mu=1 md=0), mode=RUN,
//     prescaler=0, day_tick=0, year_wrap=0. All state is registered.
//   Invariant: the date is always a valid BCD date. Day is never 00 and never
//     exceeds last_day(month). Month is always 01..12.
//   last_day: Feb=28; Apr/Jun/Sep/Nov=30; all other months=31.
//   Prescaler (RUN only):
//     - Counts 0..TICK_DIV-1 while run_en=1; holds its value while run_en=0.
//     - The edge where prescaler==TICK_DIV-1 wraps it to 0 and advances the
//       date. day_tick=1 for exactly the following cycle.
//   Date advance:
//     - day<last_day: day+1, BCD carry du 9->0 with dd+1.
//     - day==last_day: day=01; month+1.
//     - If month was 12: month=01 and year_wrap=1 (same cycle as day_tick).
//   Mode FSM (btn_mode transitions): RUN->SET_MONTH->SET_DAY->RUN.
//     - Entering SET_MONTH forces prescaler to 0.
//     - The prescaler stays 0 in both SET states, so RUN restarts a full
//       TICK_DIV period. No ticks occur in SET states.
//   SET_MONTH, on btn_inc:
//     - month+1, wrapping 12->01.
//     - In the same edge, if day > last_day(new month), day clamps to last_day.
//   SET_DAY, on btn_inc: day+1, wrapping last_day(month)->01.
//   btn_inc in RUN is ignored.
//   btn_mode and btn_inc in the same cycle: the mode transition wins and btn_inc
//     is dropped.
//   rst mid-operation (any state, mid-prescale): immediate return to reset
//     values; pending pulses are cleared.
// TESTING (TICK_DIV=4)
//   1. Reset, run_en=1 -> day_tick every 4th cycle; after 31 ticks
//      du=1 dd=0 mu=2 md=0 (01/02), year_wrap=0 throughout.
//   2. Run through month ends:
//      - 28/02 -> 01/03; 30/04 -> 01/05.
//      - 31/12 -> 01/01 with day_tick=1 and year_wrap=1 in the same cycle.
//   3. Run to 31/01; btn_mode (mode=1); btn_inc -> 28/02 (clamped).
//      Then 10 more btn_inc -> month 12, day stays 28; one more -> month 01.
//   4. In SET_DAY with month 04, day 30: btn_inc -> 01/04.
//      btn_mode -> mode=0; first day_tick comes exactly 4 cycles later.
//   5. run_en=0 for 10 cycles mid-count -> no tick, prescaler resumes.
//      btn_inc in RUN -> date unchanged.
//      btn_mode+btn_inc together in SET_MONTH -> mode=2, month unchanged.
//   6. Assert rst asynchronously mid-count in SET_DAY -> outputs 01/01,
//      mode=0, day_tick=0, year_wrap=0 before the next clk edge.

Source files
------------

// File: rtl/calendar_ctrl.sv
// Day/month BCD calendar controller: prescaled day advance in RUN, plus a
// RUN -> SET_MONTH -> SET_DAY mode FSM for setting the date from buttons.
module calendar_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] du,
  output logic [3:0] dd,
  output logic [3:0] mu,
  output logic [3:0] md,
  output logic [1:0] mode,
  output logic       day_tick,
  output logic       year_wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SET_M = 2'd1;
  localparam logic [1:0] SET_D = 2'd2;

  logic [3:0]    du_q, dd_q, mu_q, md_q;
  logic [3:0]    du_d, dd_d, mu_d, md_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [4:0] day_c, day_n;
  logic [3:0] mon_c, mon_n, mon_inc;

  function automatic logic [4:0] last_day(input logic [3:0] m);
    case (m)
      4'd2:                      return 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  // Binary 0..31 to {tens, units} BCD nibbles.
  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [4:0] t;
    logic [4:0] u;
    t = v / 5'd10;
    u = v - t * 5'd10;
    return {t[3:0], u[3:0]};
  endfunction

  // The date is kept as BCD; arithmetic is done in binary and converted back.
  assign day_c   = {1'b0, dd_q} * 5'd10 + {1'b0, du_q};
  assign mon_c   = md_q * 4'd10 + mu_q;
  assign mon_inc = (mon_c == 4'd12) ? 4'd1 : mon_c + 4'd1;

  always_comb begin
    day_n   = day_c;
    mon_n   = mon_c;
    mode_d  = mode_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    case (mode_q)
      RUN: begin
        if (btn_mode) begin
          mode_d  = SET_M;
          presc_d = '0;
        end else if (run_en) begin
          if (presc_q == PMAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (day_c < last_day(mon_c)) begin
              day_n = day_c + 5'd1;
            end else begin
              day_n  = 5'd1;
              mon_n  = mon_inc;
              wrap_d = (mon_c == 4'd12);
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      SET_M: begin
        if (btn_mode) begin
          mode_d = SET_D;
        end else if (btn_inc) begin
          mon_n = mon_inc;
          if (day_c > last_day(mon_inc)) day_n = last_day(mon_inc);
        end
      end
      SET_D: begin
        if (btn_mode) begin
          mode_d = RUN;
        end else if (btn_inc) begin
          day_n = (day_c >= last_day(mon_c)) ? 5'd1 : day_c + 5'd1;
        end
      end
      default: mode_d = RUN;
    endcase
    {dd_d, du_d} = to_bcd(day_n);
    {md_d, mu_d} = to_bcd({1'b0, mon_n});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      du_q    <= 4'd1;
      dd_q    <= 4'd0;
      mu_q    <= 4'd1;
      md_q    <= 4'd0;
      mode_q  <= RUN;
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      du_q    <= du_d;
      dd_q    <= dd_d;
      mu_q    <= mu_d;
      md_q    <= md_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign du        = du_q;
  assign dd        = dd_q;
  assign mu        = mu_q;
  assign md        = md_q;
  assign mode      = mode_q;
  assign day_tick  = tick_q;
  assign year_wrap = wrap_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Directed bench for calendar_ctrl (TICK_DIV=4): vector table plus
// hand-written month-end, setting, resume and async-reset sequences.
module tb_calendar_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run_en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] du, dd, mu, md;
  logic [1:0] mode;
  logic       day_tick, year_wrap;

  int checks = 0;
  int passed = 0;

  calendar_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .du(du), .dd(dd), .mu(mu), .md(md), .mode(mode),
    .day_tick(day_tick), .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run_en;
    logic        bm;
    logic        bi;
    logic [7:0]  ncyc;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [14];

  // Expected output word {du,dd,mu,md,mode,day_tick,year_wrap} from a date.
  function automatic logic [19:0] ev(input int d, input int m, input logic [1:0] mo,
                                     input logic t, input logic y);
    return {4'(d % 10), 4'(d / 10), 4'(m % 10), 4'(m / 10), mo, t, y};
  endfunction

  task automatic check(input string nm, input logic [19:0] exp);
    logic [19:0] act;
    act = {du, dd, mu, md, mode, day_tick, year_wrap};
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (du,dd,mu,md,{mode,tick,wrap})", nm, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run_en = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
  endtask

  task automatic pulse_inc();
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
  endtask

  // Leaves the DUT in SET_DAY at date d/m.
  task automatic goto_set_day(input int m, input int d);
    do_reset();
    pulse_mode();
    repeat (m - 1) pulse_inc();
    pulse_mode();
    repeat (d - 1) pulse_inc();
  endtask

  // Leaves the DUT in RUN at date d/m with the prescaler at 0.
  task automatic set_date(input int m, input int d);
    goto_set_day(m, d);
    pulse_mode();
  endtask

  initial begin
    int tick_cnt, bad_pos, yw_seen;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd3,  ev(1, 1, 0, 0, 0)};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd1,  ev(2, 1, 0, 1, 0)};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd2,  ev(2, 1, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd10, ev(2, 1, 0, 0, 0)};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd1,  ev(2, 1, 0, 0, 0)};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd1,  ev(3, 1, 0, 1, 0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'd1,  ev(3, 1, 0, 0, 0)};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd1,  ev(3, 1, 1, 0, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd1,  ev(3, 2, 1, 0, 0)};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'd1,  ev(3, 2, 2, 0, 0)};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'd1,  ev(4, 2, 2, 0, 0)};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd1,  ev(4, 2, 0, 0, 0)};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd3,  ev(4, 2, 0, 0, 0)};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd1,  ev(5, 2, 0, 1, 0)};

    rst = 1'b1;
    #2;
    check("reset_async", ev(1, 1, 0, 0, 0));
    step();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_en   = vecs[i].run_en;
      btn_mode = vecs[i].bm;
      btn_inc  = vecs[i].bi;
      step();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      for (int c = 1; c < int'(vecs[i].ncyc); c++) step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    do_reset();
    run_en = 1'b1;
    tick_cnt = 0; bad_pos = 0; yw_seen = 0;
    for (int c = 1; c <= 124; c++) begin
      step();
      if (day_tick) begin
        tick_cnt++;
        if (c % 4 != 0) bad_pos++;
      end
      if (year_wrap) yw_seen++;
    end
    check_int("run31_ticks", tick_cnt, 31);
    check_int("run31_phase", bad_pos, 0);
    check_int("run31_yw", yw_seen, 0);
    check("run31_date", ev(1, 2, 0, 1, 0));

    set_date(2, 28);  run_en = 1'b1; repeat (4) step();
    check("feb_end", ev(1, 3, 0, 1, 0));
    set_date(4, 30);  run_en = 1'b1; repeat (4) step();
    check("apr_end", ev(1, 5, 0, 1, 0));
    set_date(1, 9);   run_en = 1'b1; repeat (4) step();
    check("bcd_carry", ev(10, 1, 0, 1, 0));
    set_date(1, 30);  run_en = 1'b1; repeat (4) step();
    check("jan30", ev(31, 1, 0, 1, 0));
    set_date(12, 31); run_en = 1'b1; repeat (4) step();
    check("year_wrap", ev(1, 1, 0, 1, 1));
    step();
    check("wrap_one_cycle", ev(1, 1, 0, 0, 0));

    set_date(1, 31);
    pulse_mode();
    check("set_month_enter", ev(31, 1, 1, 0, 0));
    pulse_inc();
    check("clamp_feb", ev(28, 2, 1, 0, 0));
    repeat (10) pulse_inc();
    check("month12", ev(28, 12, 1, 0, 0));
    pulse_inc();
    check("month_wrap", ev(28, 1, 1, 0, 0));

    goto_set_day(4, 30);
    check("setday_30apr", ev(30, 4, 2, 0, 0));
    pulse_inc();
    check("day_wrap", ev(1, 4, 2, 0, 0));
    run_en = 1'b1;
    pulse_mode();
    check("back_to_run", ev(1, 4, 0, 0, 0));
    repeat (3) step();
    check("restart_no_tick", ev(1, 4, 0, 0, 0));
    step();
    check("restart_tick", ev(2, 4, 0, 1, 0));

    set_date(12, 31); run_en = 1'b1; repeat (4) step();
    #2 rst = 1'b1;
    #1 check("rst_clears_pulses", ev(1, 1, 0, 0, 0));
    step();
    rst = 1'b0;

    goto_set_day(3, 15);
    run_en = 1'b1;
    step(); step();
    #2 rst = 1'b1;
    #1 check("rst_in_setday", ev(1, 1, 0, 0, 0));
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
